// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg: shared definitions for the digital clock mode/time-set controller.
//   - mode encodings (also the value driven on the mode output)
//   - blink_hide bit positions, button lane indices
//   - default timing constants (tick_1khz / tick_1hz periods)
//   - strobe bundle struct for the registered one-cycle outputs
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam int MODE_W  = 2;
    localparam int BLINK_W = 3;

    // blink_hide bit positions
    localparam int BLINK_HOUR = 2;
    localparam int BLINK_MIN  = 1;
    localparam int BLINK_SEC  = 0;

    // button lanes
    localparam int NUM_BTN  = 2;
    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;

    // default timing, in tick_1khz periods unless noted
    localparam int DEF_DEB_MS          = 20;
    localparam int DEF_REPEAT_DELAY_MS = 500;
    localparam int DEF_REPEAT_RATE_MS  = 100;
    localparam int DEF_BLINK_HALF_MS   = 250;
    localparam int DEF_TIMEOUT_S       = 30;   // tick_1hz periods

    typedef struct packed {
        logic sec_tick;
        logic hour_inc;
        logic min_inc;
        logic sec_clr;
    } strobe_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl_if: timebase/button inputs and time-counter control outputs
// of the mode/time-set controller.
//   master : environment side (drives ticks and buttons, observes strobes)
//   slave  : controller side
// Signals: tick_1khz, tick_1hz, btn_mode, btn_inc (to controller);
//          sec_tick, hour_inc, min_inc, sec_clr, mode[1:0], blink_hide[2:0]
// ---------------------------------------------------------------------------
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic               tick_1khz;
    logic               tick_1hz;
    logic               btn_mode;
    logic               btn_inc;
    logic               sec_tick;
    logic               hour_inc;
    logic               min_inc;
    logic               sec_clr;
    logic [MODE_W-1:0]  mode;
    logic [BLINK_W-1:0] blink_hide;

    modport master (
        output tick_1khz, tick_1hz, btn_mode, btn_inc,
        input  sec_tick, hour_inc, min_inc, sec_clr, mode, blink_hide
    );

    modport slave (
        input  tick_1khz, tick_1hz, btn_mode, btn_inc,
        output sec_tick, hour_inc, min_inc, sec_clr, mode, blink_hide
    );

endinterface

// File: rtl/clock_set_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce: one button lane.
//   2-FF synchroniser -> debounce counter on tick -> rising-edge press pulse.
// Ports:
//   CP, CR  clock, async active-high reset
//   tick    1-cycle enable (1 kHz) that paces the debounce counter
//   raw     asynchronous button level, 1 = pressed
//   level   debounced level
//   press   one-cycle pulse on debounced 0->1
// ---------------------------------------------------------------------------
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEB_MS = DEF_DEB_MS
)(
    input  logic CP,
    input  logic CR,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MS - 1);

    logic [1:0]    sync;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            sync    <= 2'b00;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            if (tick) begin
                if (sync[1] != level) begin
                    // DEB_MS-th consecutive mismatching tick commits the new level
                    if (cnt == CNT_LAST) begin
                        level <= sync[1];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl: mode and time-set controller for the digital clock.
// Sits between the timebase divider and the hour/min/sec counters.
// Ports:
//   CP   system clock
//   CR   async active-high reset
//   bus  clock_set_ctrl_if.slave
//        in : tick_1khz, tick_1hz (1-cycle enables), btn_mode, btn_inc (raw)
//        out: sec_tick, hour_inc, min_inc, sec_clr (1-cycle strobes),
//             mode (RUN/SET_HOUR/SET_MIN/SET_SEC), blink_hide[2:0]
// Behaviour summary: MODE presses step RUN->HOUR->MIN->SEC->RUN; INC presses
// and auto-repeat issue the strobe for the field being set; idle set states
// fall back to RUN after TIMEOUT_S seconds; the field being set blinks.
// ---------------------------------------------------------------------------
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_MS          = DEF_DEB_MS,
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
    parameter int BLINK_HALF_MS   = DEF_BLINK_HALF_MS,
    parameter int TIMEOUT_S       = DEF_TIMEOUT_S
)(
    input  logic          CP,
    input  logic          CR,
    clock_set_ctrl_if.slave bus
);
    localparam int HOLD_MAX = max_int(REPEAT_DELAY_MS, REPEAT_RATE_MS);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int BW = $clog2(BLINK_HALF_MS + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY_MS - 1);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE_MS - 1);
    localparam logic [HW-1:0] HOLD_TOP   = HW'(HOLD_MAX);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_MS - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_S - 1);

    // ---------------- button lanes ----------------
    logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_prs;

    assign btn_raw[BTN_MODE] = bus.btn_mode;
    assign btn_raw[BTN_INC]  = bus.btn_inc;

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_debounce #(.DEB_MS(DEB_MS)) u_deb (
                .CP    (CP),
                .CR    (CR),
                .tick  (bus.tick_1khz),
                .raw   (btn_raw[g]),
                .level (btn_lvl[g]),
                .press (btn_prs[g])
            );
        end
    endgenerate

    // MODE only acts on its press pulse; its debounced level has no consumer.
    logic unused_mode_lvl;
    assign unused_mode_lvl = btn_lvl[BTN_MODE];

    logic mode_ev, inc_ev, inc_lvl;
    assign mode_ev = btn_prs[BTN_MODE];
    assign inc_ev  = btn_prs[BTN_INC];
    assign inc_lvl = btn_lvl[BTN_INC];

    // ---------------- state / counters ----------------
    mode_e         state_q, state_d;
    logic [HW-1:0] hold_cnt;
    logic          rep_on;      // past the initial delay, now on the repeat rate
    logic [BW-1:0] blink_cnt;
    logic          hide;
    logic [TW-1:0] to_cnt;
    strobe_t       stb_q, stb_d;

    logic in_set, rep_fire, timeout, fire, state_chg;

    always_comb begin
        state_d = state_q;
        stb_d   = '0;
        in_set  = (state_q != MODE_RUN);

        rep_fire = bus.tick_1khz && in_set && inc_lvl &&
                   (hold_cnt == (rep_on ? RATE_LAST : DELAY_LAST));
        timeout  = bus.tick_1hz && in_set && (to_cnt == TO_LAST);
        // MODE wins over INC; a forced return to RUN issues no strobe
        fire     = ((inc_ev && in_set) || rep_fire) && !mode_ev && !timeout;

        if (mode_ev) begin
            unique case (state_q)
                MODE_RUN:      state_d = MODE_SET_HOUR;
                MODE_SET_HOUR: state_d = MODE_SET_MIN;
                MODE_SET_MIN:  state_d = MODE_SET_SEC;
                MODE_SET_SEC:  state_d = MODE_RUN;
                default:       state_d = MODE_RUN;
            endcase
        end else if (timeout) begin
            state_d = MODE_RUN;
        end

        state_chg = (state_d != state_q);

        // seconds keep running except while the seconds field is being set
        stb_d.sec_tick = bus.tick_1hz && (state_q != MODE_SET_SEC);
        stb_d.hour_inc = fire && (state_q == MODE_SET_HOUR);
        stb_d.min_inc  = fire && (state_q == MODE_SET_MIN);
        stb_d.sec_clr  = fire && (state_q == MODE_SET_SEC);
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= MODE_RUN;
            stb_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
        end
    end

    // auto-repeat hold counter: ticks since press, then since last repeat
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            hold_cnt <= '0;
            rep_on   <= 1'b0;
        end else if (!in_set || !inc_lvl || mode_ev || state_chg) begin
            hold_cnt <= '0;
            rep_on   <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt <= '0;
            rep_on   <= 1'b1;
        end else if (bus.tick_1khz && hold_cnt != HOLD_TOP) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // inactivity timeout in set states, seconds since last user activity
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            to_cnt <= '0;
        end else if (!in_set || mode_ev || inc_ev || rep_fire) begin
            to_cnt <= '0;
        end else if (bus.tick_1hz && to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // blink phase: restart visible on state entry and on every strobe so the
    // user sees the new value immediately
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            blink_cnt <= '0;
            hide      <= 1'b0;
        end else if (!in_set || state_chg || fire) begin
            blink_cnt <= '0;
            hide      <= 1'b0;
        end else if (bus.tick_1khz) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                hide      <= ~hide;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    logic [BLINK_W-1:0] blink;

    always_comb begin
        blink = '0;
        unique case (state_q)
            MODE_SET_HOUR: blink[BLINK_HOUR] = hide;
            MODE_SET_MIN:  blink[BLINK_MIN]  = hide;
            MODE_SET_SEC:  blink[BLINK_SEC]  = hide;
            default:       blink = '0;
        endcase
    end

    assign bus.sec_tick   = stb_q.sec_tick;
    assign bus.hour_inc   = stb_q.hour_inc;
    assign bus.min_inc    = stb_q.min_inc;
    assign bus.sec_clr    = stb_q.sec_clr;
    assign bus.mode       = state_q;
    assign bus.blink_hide = blink;

endmodule
